// File: rtl/rc5_io_guard_if.sv
// Tap/alarm bundle between the RC5 core top level and its integrity monitor.
// RC5_GUARD_GATE_EN adds the masked response datapath (dout_in / dout_out).
interface rc5_io_guard_if #(
  parameter int KEY_W   = 128,
  parameter int DATA_W  = 64,
  parameter int MAX_OUT = 4,
  parameter int CNT_W   = 8
);
  localparam int OUT_W = $clog2(MAX_OUT + 1);

  logic [KEY_W-1:0] key;
  logic             key_en;
  logic             key_ok;
  logic             din_en;
  logic             dout_en;
  logic             alarm_clr;
  logic             alarm;
  logic [2:0]       alarm_code;
  logic [CNT_W-1:0] viol_cnt;
  logic [OUT_W-1:0] outstanding;

`ifdef RC5_GUARD_GATE_EN
  logic [DATA_W-1:0] dout_in;
  logic [DATA_W-1:0] dout_out;

  modport master (
    output key, key_en, key_ok, din_en, dout_en, alarm_clr, dout_in,
    input  alarm, alarm_code, viol_cnt, outstanding, dout_out
  );

  modport slave (
    input  key, key_en, key_ok, din_en, dout_en, alarm_clr, dout_in,
    output alarm, alarm_code, viol_cnt, outstanding, dout_out
  );
`else
  modport master (
    output key, key_en, key_ok, din_en, dout_en, alarm_clr,
    input  alarm, alarm_code, viol_cnt, outstanding
  );

  modport slave (
    input  key, key_en, key_ok, din_en, dout_en, alarm_clr,
    output alarm, alarm_code, viol_cnt, outstanding
  );
`endif
endinterface

// File: rtl/rc5_io_guard.sv
// Runtime integrity monitor for the RC5 core: key stability, request/response balance, latency.
// Define RC5_GUARD_GATE_EN to also blank the response data while the alarm is raised.
module rc5_io_guard #(
  parameter int KEY_W   = 128,
  parameter int DATA_W  = 64,
  parameter int MAX_OUT = 4,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 8
) (
  input  logic           clk,
  input  logic           rst,
  rc5_io_guard_if.slave  bus
);
  localparam int OUT_W = $clog2(MAX_OUT + 1);
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [OUT_W-1:0] OUT_MAX  = OUT_W'(MAX_OUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_PARK = TMR_W'(TIMEOUT);

  if (MAX_OUT < 1 || TIMEOUT < 2 || DATA_W < 1) begin : g_param_check
    $error("rc5_io_guard: illegal parameter set");
  end

  typedef enum logic [1:0] {DISARMED, ARMED, ALARM} state_t;

  state_t           state, state_next;
  logic [KEY_W-1:0] key_q;
  logic [OUT_W-1:0] out_q, out_next;
  logic [TMR_W-1:0] timer, timer_next;
  logic             alarm_q;
  logic [2:0]       code_q, code_next;
  logic [CNT_W-1:0] cnt_q, cnt_next;
  logic [2:0]       viol;
  logic             any_viol;
  logic             checking;

  always_comb begin
    checking = (state != DISARMED);
    viol     = '0;
    viol[0]  = checking && !bus.key_en && (bus.key != key_q);
    viol[1]  = checking && ((bus.dout_en && !bus.din_en && out_q == '0) ||
                            (bus.din_en && !bus.dout_en && out_q == OUT_MAX));
    viol[2]  = checking && (out_q != '0) && !bus.dout_en && (timer == TMR_LAST);
    any_viol = |viol;
  end

  always_comb begin
    out_next = out_q;
    if (bus.din_en && !bus.dout_en && out_q != OUT_MAX) begin
      out_next = out_q + 1'b1;
    end else if (bus.dout_en && !bus.din_en && out_q != '0) begin
      out_next = out_q - 1'b1;
    end
  end

  // Timer parks one past the limit so a single stall raises exactly one timeout.
  always_comb begin
    timer_next = timer;
    if (out_q == '0 || bus.dout_en) begin
      timer_next = '0;
    end else if (timer != TMR_PARK) begin
      timer_next = timer + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      DISARMED: if (bus.key_ok) state_next = ARMED;
      ARMED:    if (any_viol) state_next = ALARM;
      ALARM:    if (bus.alarm_clr && !any_viol) state_next = ARMED;
      default:  state_next = DISARMED;
    endcase
  end

  always_comb begin
    code_next = '0;
    if (state_next == ALARM) begin
      code_next = code_q | viol;
    end
    cnt_next = cnt_q;
    if (any_viol && cnt_q != {CNT_W{1'b1}}) begin
      cnt_next = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= DISARMED;
      key_q   <= '0;
      out_q   <= '0;
      timer   <= '0;
      alarm_q <= 1'b0;
      code_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state   <= state_next;
      key_q   <= bus.key;
      out_q   <= out_next;
      timer   <= timer_next;
      alarm_q <= (state_next == ALARM);
      code_q  <= code_next;
      cnt_q   <= cnt_next;
    end
  end

  assign bus.alarm       = alarm_q;
  assign bus.alarm_code  = code_q;
  assign bus.viol_cnt    = cnt_q;
  assign bus.outstanding = out_q;

`ifdef RC5_GUARD_GATE_EN
  assign bus.dout_out = alarm_q ? '0 : bus.dout_in;
`endif
endmodule
